// File: rtl/seq_detect_param_if.sv
// Serial pattern detector bus: stream controls in, match tick and counter out.
interface seq_detect_param_if #(
    parameter int SEQ_LEN = 4,
    parameter int CNT_W   = 8
);
    logic               seq;
    logic               en;
    logic               overlap;
    logic               pat_ld;
    logic [SEQ_LEN-1:0] pattern_in;
    logic               cnt_clr;
    logic               tick;
    logic [CNT_W-1:0]   match_cnt;
    logic               cnt_sat;

    modport master (
        output seq, en, overlap, pat_ld, pattern_in, cnt_clr,
        input  tick, match_cnt, cnt_sat
    );

    modport slave (
        input  seq, en, overlap, pat_ld, pattern_in, cnt_clr,
        output tick, match_cnt, cnt_sat
    );
endinterface

// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector with reloadable pattern and overlap mode.
// Match counter present only when SEQ_DETECT_CNT_EN is defined.
module seq_detect_param #(
    parameter int                 SEQ_LEN = 4,
    parameter logic [SEQ_LEN-1:0] PATTERN = 4'b1101,
    parameter int                 CNT_W   = 8
) (
    input logic             clk,
    input logic             rst,
    seq_detect_param_if.slave bus
);
    localparam int FW = $clog2(SEQ_LEN + 1);

    logic [SEQ_LEN-1:0] pat_q, pat_d;
    logic [SEQ_LEN-1:0] hist_q, hist_d, hist_n;
    logic [FW-1:0]      fill_q, fill_d, fill_n;
    logic               tick_q, tick_d;
    logic               hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q  <= PATTERN;
            hist_q <= '0;
            fill_q <= '0;
            tick_q <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            tick_q <= tick_d;
        end
    end

    always_comb begin
        hist_n = {hist_q[SEQ_LEN-2:0], bus.seq};
        fill_n = (fill_q == FW'(SEQ_LEN)) ? fill_q : fill_q + 1'b1;
        hit    = 1'b0;
        pat_d  = pat_q;
        hist_d = hist_q;
        fill_d = fill_q;
        tick_d = 1'b0;
        // A reload outranks sampling: the bit on seq is dropped that cycle
        if (bus.pat_ld) begin
            pat_d  = bus.pattern_in;
            hist_d = '0;
            fill_d = '0;
        end else if (bus.en) begin
            hit    = (fill_n == FW'(SEQ_LEN)) && (hist_n == pat_q);
            hist_d = hist_n;
            fill_d = (hit && !bus.overlap) ? '0 : fill_n;
            tick_d = hit;
        end
    end

    assign bus.tick = tick_q;

`ifdef SEQ_DETECT_CNT_EN
    logic [CNT_W-1:0] cnt_q;
    logic             sat;

    assign sat = &cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (bus.cnt_clr) begin
            cnt_q <= '0;
        end else if (hit && !sat) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.match_cnt = cnt_q;
    assign bus.cnt_sat   = sat;
`else
    logic unused_cnt;

    assign unused_cnt    = bus.cnt_clr;
    assign bus.match_cnt = '0;
    assign bus.cnt_sat   = 1'b0;
`endif
endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench: default detector (CNT_W=8) and a CNT_W=2 copy on one stream.
module tb_seq_detect_param;
`ifdef SEQ_DETECT_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       seq, en, overlap, pat_ld, cnt_clr;
    logic [3:0] pattern_in;
    int         n_cmp = 0;
    int         n_err = 0;

    seq_detect_param_if #(.SEQ_LEN(4), .CNT_W(8)) ifa ();
    seq_detect_param_if #(.SEQ_LEN(4), .CNT_W(2)) ifb ();

    assign ifa.seq        = seq;
    assign ifa.en         = en;
    assign ifa.overlap    = overlap;
    assign ifa.pat_ld     = pat_ld;
    assign ifa.pattern_in = pattern_in;
    assign ifa.cnt_clr    = cnt_clr;
    assign ifb.seq        = seq;
    assign ifb.en         = en;
    assign ifb.overlap    = overlap;
    assign ifb.pat_ld     = pat_ld;
    assign ifb.pattern_in = pattern_in;
    assign ifb.cnt_clr    = cnt_clr;

    seq_detect_param #(.SEQ_LEN(4), .PATTERN(4'b1101), .CNT_W(8)) u_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    seq_detect_param #(.SEQ_LEN(4), .PATTERN(4'b1101), .CNT_W(2)) u_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ce(int v);
        return CNT_ON ? 32'(v) : 32'd0;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic step(string tag, logic s, logic t);
        seq = s;
        en  = 1'b1;
        cyc();
        chk({tag, " tick_a"}, 32'(ifa.tick), 32'(t));
        chk({tag, " tick_b"}, 32'(ifb.tick), 32'(t));
    endtask

    task automatic idle(string tag, logic s);
        seq = s;
        en  = 1'b0;
        cyc();
        chk({tag, " tick_a"}, 32'(ifa.tick), 32'd0);
    endtask

    task automatic cnts(string tag, int a, int b, int sb);
        chk({tag, " cnt_a"}, 32'(ifa.match_cnt), ce(a));
        chk({tag, " cnt_b"}, 32'(ifb.match_cnt), ce(b));
        chk({tag, " sat_a"}, 32'(ifa.cnt_sat), 32'd0);
        chk({tag, " sat_b"}, 32'(ifb.cnt_sat), ce(sb));
    endtask

    // reload 1101, drop history, zero the counters
    task automatic restart();
        en         = 1'b0;
        pat_ld     = 1'b1;
        pattern_in = 4'b1101;
        cnt_clr    = 1'b1;
        cyc();
        pat_ld  = 1'b0;
        cnt_clr = 1'b0;
        chk("restart tick", 32'(ifa.tick), 32'd0);
        cnts("restart", 0, 0, 0);
    endtask

    initial begin
        rst        = 1'b1;
        seq        = 1'b0;
        en         = 1'b0;
        overlap    = 1'b1;
        pat_ld     = 1'b0;
        pattern_in = 4'b0000;
        cnt_clr    = 1'b0;
        cyc();
        cyc();
        chk("reset tick_a", 32'(ifa.tick), 32'd0);
        chk("reset tick_b", 32'(ifb.tick), 32'd0);
        cnts("reset", 0, 0, 0);
        rst = 1'b0;

        overlap = 1'b1;
        step("t1 b1", 1, 0);
        step("t1 b2", 1, 0);
        step("t1 b3", 0, 0);
        step("t1 b4", 1, 1);
        step("t1 b5", 1, 0);
        step("t1 b6", 0, 0);
        step("t1 b7", 1, 1);
        cnts("t1", 2, 2, 0);

        restart();
        overlap = 1'b0;
        step("t2 b1", 1, 0);
        step("t2 b2", 1, 0);
        step("t2 b3", 0, 0);
        step("t2 b4", 1, 1);
        step("t2 b5", 1, 0);
        step("t2 b6", 0, 0);
        step("t2 b7", 1, 0);
        cnts("t2", 1, 1, 0);

        restart();
        overlap = 1'b1;
        step("t3 b1", 1, 0);
        step("t3 b2", 1, 0);
        step("t3 b3", 0, 0);
        seq = 1'b1;
        en  = 1'b1;
        rst = 1'b1;
        #1;
        chk("t3 in-rst tick", 32'(ifa.tick), 32'd0);
        cnts("t3 in-rst", 0, 0, 0);
        cyc();
        rst = 1'b0;
        chk("t3 post-rst tick", 32'(ifa.tick), 32'd0);
        step("t3 r1", 1, 0);
        step("t3 r2", 1, 0);
        step("t3 r3", 1, 0);
        step("t3 r4", 0, 0);
        step("t3 r5", 1, 1);
        cnts("t3", 1, 1, 0);

        restart();
        overlap = 1'b1;
        step("t4 b1", 1, 0);
        step("t4 b2", 1, 0);
        idle("t4 g1", 0);
        idle("t4 g2", 1);
        idle("t4 g3", 0);
        step("t4 b3", 0, 0);
        step("t4 b4", 1, 1);
        cnts("t4", 1, 1, 0);

        restart();
        overlap = 1'b0;
        step("t5 p1", 0, 0);
        step("t5 p2", 1, 0);
        seq        = 1'b1;
        en         = 1'b1;
        pat_ld     = 1'b1;
        pattern_in = 4'b0110;
        cyc();
        pat_ld = 1'b0;
        chk("t5 ld tick", 32'(ifa.tick), 32'd0);
        step("t5 b1", 0, 0);
        step("t5 b2", 1, 0);
        step("t5 b3", 1, 0);
        step("t5 b4", 0, 1);
        step("t5 c1", 1, 0);
        step("t5 c2", 1, 0);
        step("t5 c3", 0, 0);
        step("t5 c4", 1, 0);
        cnts("t5", 1, 1, 0);

        restart();
        overlap = 1'b1;
        step("t6 lead", 1, 0);
        for (int r = 0; r < 5; r++) begin
            step("t6 x1", 1, 0);
            step("t6 x0", 0, 0);
            step("t6 x1h", 1, 1);
            cnts("t6 rep", r + 1, (r < 3) ? r + 1 : 3, (r >= 2) ? 1 : 0);
        end
        step("t6 y1", 1, 0);
        step("t6 y0", 0, 0);
        cnt_clr = 1'b1;
        step("t6 clr-hit", 1, 1);
        cnt_clr = 1'b0;
        cnts("t6 clr", 0, 0, 0);
        step("t6 z1", 1, 0);
        step("t6 z0", 0, 0);
        step("t6 z1h", 1, 1);
        cnts("t6 after", 1, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
- Parametrised serial bit-pattern detector; successor to the fixed 4-bit, 2-state-bit detector.
- Pattern length and reset pattern are set by parameters. The pattern can be reloaded at run time.
- Selectable overlapping / non-overlapping match mode, input-enable gating, and a saturating match counter.
- Sits on a 1-bit serial stream in the protocol front-end. Its tick feeds frame-sync and interrupt logic.

Parameters:
- SEQ_LEN, 4, pattern length in bits; legal range 2..32.
- PATTERN, 4'b1101, reset value of the pattern register, SEQ_LEN bits wide. The MSB is the first bit received.
- CNT_W, 8, width of the match counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- seq  input  1  serial data bit; sampled only when en=1
- en  input  1  sample-enable; when low, all state holds
- overlap  input  1  1 = overlapping matches allowed; 0 = history restarts after each match
- pat_ld  input  1  load pattern_in into the pattern register
- pattern_in  input  SEQ_LEN  new pattern (MSB = first bit)
- cnt_clr  input  1  synchronous clear of match_cnt
- tick  output  1  one-cycle registered match pulse
- match_cnt  output  CNT_W  saturating count of matches
- cnt_sat  output  1  high while match_cnt is at its all-ones maximum

Behaviour:
- Reset (asynchronous, rst=1):
  - pattern register <= PATTERN; history <= 0; fill <= 0.
  - tick=0, match_cnt=0, cnt_sat=0.
  - Reset mid-sequence discards all partial progress.
- State:
  - hist[SEQ_LEN-1:0] shift register.
  - fill counter, 0..SEQ_LEN: number of valid bits held in hist.
- Priority each cycle: pat_ld > en. cnt_clr is independent.
- pat_ld=1:
  - pattern register <= pattern_in; hist <= 0; fill <= 0; tick <= 0.
  - seq is ignored in that cycle, even if en=1.
- en=1 and pat_ld=0:
  - hist_n = {hist[SEQ_LEN-2:0], seq}; fill_n = min(fill+1, SEQ_LEN).
  - hit = (fill_n == SEQ_LEN) && (hist_n == pattern).
  - hist <= hist_n.
  - fill <= 0 if hit and overlap=0; otherwise fill <= fill_n.
  - tick <= hit.
- en=0 and pat_ld=0: hist and fill hold; tick <= 0.
- Latency: tick is high in the cycle after the clock edge that samples the final pattern bit. It lasts exactly one cycle per match.
- Overlap mode:
  - overlap=1: the tail of a match may start the next match (1101101 gives two hits for pattern 1101).
  - overlap=0: a new match needs SEQ_LEN fresh bits after the previous hit.
  - overlap may change at any time; it takes effect on the next sampled bit.
- Counter:
  - On hit, match_cnt <= match_cnt+1 unless already all-ones; it then holds (saturates, no wrap).
  - cnt_clr=1 sets match_cnt <= 0. If cnt_clr and hit occur in the same cycle, the result is 0 (clear wins).
  - cnt_sat = (match_cnt == all-ones), decoded from the registered match_cnt.
- Pattern reload mid-stream: partial history is discarded. Detection of the new pattern needs SEQ_LEN new bits.
- All outputs are registered or decoded from registers; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: SEQ_DETECT_CNT_EN.
- Defined: match_cnt and cnt_sat are implemented exactly as specified above.
- Undefined:
  - Counter logic is removed.
  - match_cnt is tied to 0 and cnt_sat to 0; cnt_clr is ignored.
  - tick, overlap and pattern behaviour are unchanged.

Test Plan:
1. Defaults, overlap=1, en=1, seq stream 1,1,0,1,1,0,1 → tick pulses one cycle after the 4th bit and after the 7th bit; match_cnt=2.
2. Same stream with overlap=0 → single tick after the 4th bit; bits 5-7 do not match; match_cnt=1.
3. Feed 1,1,0, assert rst for 1 cycle, then feed 1 → no tick; all outputs 0 during and after reset. Next, 1,1,0,1 → tick.
4. Stream 1,1,0,1 with en=0 for 3 cycles between bits 2 and 3; seq toggles during the gap → gap bits ignored, tick after the 4th enabled bit.
5. pat_ld with pattern_in=4'b0110 after bits 0,1 are received, then stream 0,1,1,0 → tick after the 4th post-load bit. Stream 1,1,0,1 → no tick.
6. CNT_W=2, overlap=1, stream 1 followed by 101 repeated 5 times → 5 ticks; match_cnt stops at 3 and cnt_sat=1. Then cnt_clr pulses together with a hit → match_cnt=0.
